// File: rtl/hwpe_ctrl_loop_seq.sv
// Nested-loop iteration sequencer: walks NB_LOOPS nested counters (loop 0 innermost),
// presenting indices, accumulated offsets and an accumulate flag, one iteration per handshake.
module hwpe_ctrl_loop_seq #(
    parameter int unsigned NB_LOOPS  = 6,
    parameter int unsigned NB_REG    = 4,
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 12,
    localparam int unsigned LW       = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  start_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]         range_i,
    input  logic [NB_LOOPS*NB_REG*REG_WIDTH-1:0]  stride_i,
    input  logic [LW-1:0]                         accum_loop_i,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]         idx_o,
    output logic [NB_REG*REG_WIDTH-1:0]           offs_o,
    output logic                                  accum_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int unsigned SW = NB_LOOPS * NB_REG * REG_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   range_q [NB_LOOPS];
    logic [CNT_WIDTH-1:0]   range_d [NB_LOOPS];
    logic [SW-1:0]          stride_q, stride_d;
    logic [LW-1:0]          accum_loop_q, accum_loop_d;
    logic [CNT_WIDTH-1:0]   idx_q [NB_LOOPS];
    logic [CNT_WIDTH-1:0]   idx_d [NB_LOOPS];
    logic [REG_WIDTH-1:0]   offs_q [NB_REG];
    logic [REG_WIDTH-1:0]   offs_d [NB_REG];
    logic                   valid_q, busy_q, done_q, accum_q, accum_d;

    logic [CNT_WIDTH-1:0]   eff_range [NB_LOOPS];
    logic [NB_LOOPS-1:0]    at_last;
    logic [LW-1:0]          sel;
    logic                   carry;
    logic [REG_WIDTH-1:0]   step;

    // Effective trip counts (0 means 1) and per-loop last-index flags
    always_comb begin
        for (int unsigned l = 0; l < NB_LOOPS; l++) begin
            eff_range[l] = (range_q[l] == '0) ? CNT_WIDTH'(1) : range_q[l];
            at_last[l]   = (idx_q[l] == eff_range[l] - CNT_WIDTH'(1));
        end
    end

    // Next-state, counter advance, offset update and accumulate flag
    always_comb begin
        state_d      = state_q;
        range_d      = range_q;
        stride_d     = stride_q;
        accum_loop_d = accum_loop_q;
        idx_d        = idx_q;
        offs_d       = offs_q;
        sel          = '0;
        carry        = 1'b1;
        step         = '0;
        accum_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    for (int unsigned l = 0; l < NB_LOOPS; l++) begin
                        range_d[l] = range_i[l*CNT_WIDTH +: CNT_WIDTH];
                        idx_d[l]   = '0;
                    end
                    for (int unsigned r = 0; r < NB_REG; r++) begin
                        offs_d[r] = '0;
                    end
                    stride_d     = stride_i;
                    accum_loop_d = accum_loop_i;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (ready_i) begin
                    if (&at_last) begin
                        state_d = DONE;
                    end else begin
                        // Ripple: wrap saturated inner loops, bump the first one that is not
                        for (int unsigned l = 0; l < NB_LOOPS; l++) begin
                            if (carry) begin
                                if (at_last[l]) begin
                                    idx_d[l] = '0;
                                end else begin
                                    idx_d[l] = idx_q[l] + CNT_WIDTH'(1);
                                    sel      = LW'(l);
                                    carry    = 1'b0;
                                end
                            end
                        end
                        for (int unsigned r = 0; r < NB_REG; r++) begin
                            step = '0;
                            for (int unsigned l = 0; l < NB_LOOPS; l++) begin
                                if (sel == LW'(l)) begin
                                    step = stride_q[(l*NB_REG+r)*REG_WIDTH +: REG_WIDTH];
                                end
                            end
                            offs_d[r] = offs_q[r] + step;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Soft clear overrides everything, including a pending start or accept
        if (clear_i) begin
            state_d      = IDLE;
            stride_d     = '0;
            accum_loop_d = '0;
            for (int unsigned l = 0; l < NB_LOOPS; l++) begin
                range_d[l] = '0;
                idx_d[l]   = '0;
            end
            for (int unsigned r = 0; r < NB_REG; r++) begin
                offs_d[r] = '0;
            end
        end

        // First iteration of a group: all indices up to the boundary loop are zero
        for (int unsigned k = 0; k < NB_LOOPS; k++) begin
            if ((LW'(k) <= accum_loop_d) && (idx_d[k] != '0)) begin
                accum_d = 1'b1;
            end
        end
    end

    // State, latched configuration, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            stride_q     <= '0;
            accum_loop_q <= '0;
            for (int unsigned l = 0; l < NB_LOOPS; l++) begin
                range_q[l] <= '0;
                idx_q[l]   <= '0;
            end
            for (int unsigned r = 0; r < NB_REG; r++) begin
                offs_q[r] <= '0;
            end
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            accum_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            stride_q     <= stride_d;
            accum_loop_q <= accum_loop_d;
            range_q      <= range_d;
            idx_q        <= idx_d;
            offs_q       <= offs_d;
            valid_q      <= (state_d == RUN);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            accum_q      <= accum_d;
        end
    end

    // Flatten counter and offset arrays onto the output buses
    for (genvar l = 0; l < NB_LOOPS; l++) begin : g_idx
        assign idx_o[l*CNT_WIDTH +: CNT_WIDTH] = idx_q[l];
    end
    for (genvar r = 0; r < NB_REG; r++) begin : g_offs
        assign offs_o[r*REG_WIDTH +: REG_WIDTH] = offs_q[r];
    end

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign accum_o = accum_q;

endmodule

// File: tb/tb_hwpe_ctrl_loop_seq.sv
// Directed self-checking bench for the nested-loop sequencer.
module tb_hwpe_ctrl_loop_seq;

    localparam int unsigned NL = 6;
    localparam int unsigned NR = 4;
    localparam int unsigned RW = 32;
    localparam int unsigned CW = 12;
    localparam int unsigned LW = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  clear;
    logic                  start;
    logic [NL*CW-1:0]      range_v;
    logic [NL*NR*RW-1:0]   stride_v;
    logic [LW-1:0]         accum_loop;
    logic                  valid;
    logic                  ready;
    logic [NL*CW-1:0]      idx;
    logic [NR*RW-1:0]      offs;
    logic                  accum;
    logic                  busy;
    logic                  done;

    int n_chk  = 0;
    int n_fail = 0;

    hwpe_ctrl_loop_seq #(
        .NB_LOOPS  (NL),
        .NB_REG    (NR),
        .REG_WIDTH (RW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .start_i      (start),
        .range_i      (range_v),
        .stride_i     (stride_v),
        .accum_loop_i (accum_loop),
        .valid_o      (valid),
        .ready_i      (ready),
        .idx_o        (idx),
        .offs_o       (offs),
        .accum_o      (accum),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] get_idx(input int l);
        return idx[l*CW +: CW];
    endfunction

    task automatic set_ranges(input int r0, input int r1);
        for (int l = 0; l < NL; l++) range_v[l*CW +: CW] = CW'(1);
        range_v[0 +: CW]  = CW'(r0);
        range_v[CW +: CW] = CW'(r1);
    endtask

    task automatic kick(input logic [LW-1:0] al);
        accum_loop = al;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    int e0 [6] = '{0, 1, 2, 0, 1, 2};
    int e1 [6] = '{0, 0, 0, 1, 1, 1};
    int eo [6] = '{0, 4, 8, 0, 4, 8};
    int a0 [6] = '{0, 1, 0, 1, 0, 1};
    int a1 [6] = '{0, 1, 1, 1, 1, 1};
    int q0 [4] = '{0, 1, 0, 1};
    int q1 [4] = '{0, 0, 1, 1};

    initial begin
        logic seen;
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; ready = 1'b1;
        range_v = '0; stride_v = '0; accum_loop = '0;

        // Reset state
        #12;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_accum", 64'(accum), 64'd0);
        chk("rst_idx",   64'(idx == '0), 64'd1);
        chk("rst_offs",  64'(offs == '0), 64'd1);
        rst_n = 1'b1;
        tick();

        // Test 1: ranges {3,2}, strides +4 / -8 on reg 0; late input changes ignored
        stride_v[0 +: RW]   = 32'd4;
        stride_v[128 +: RW] = 32'hFFFF_FFF8;
        set_ranges(3, 2);
        kick(3'd0);
        stride_v[0 +: RW] = 32'd100;
        range_v[0 +: CW]  = CW'(5);
        for (int i = 0; i < 6; i++) begin
            chk("t1_valid", 64'(valid), 64'd1);
            chk("t1_busy",  64'(busy), 64'd1);
            chk("t1_idx0",  64'(get_idx(0)), 64'(e0[i]));
            chk("t1_idx1",  64'(get_idx(1)), 64'(e1[i]));
            chk("t1_offs0", 64'(offs[0 +: RW]), 64'(eo[i]));
            chk("t1_done_low", 64'(done), 64'd0);
            tick();
        end
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_valid_off", 64'(valid), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Test 2: all ranges 1, start during DONE ignored
        set_ranges(1, 1);
        kick(3'd0);
        chk("t2_valid", 64'(valid), 64'd1);
        chk("t2_idx",   64'(idx == '0), 64'd1);
        chk("t2_offs",  64'(offs == '0), 64'd1);
        tick();
        chk("t2_done",  64'(done), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_idle_valid", 64'(valid), 64'd0);
        chk("t2_idle_busy",  64'(busy), 64'd0);
        chk("t2_done_once",  64'(done), 64'd0);

        // Test 3: range0 = 0 behaves as 1
        set_ranges(0, 2);
        kick(3'd0);
        for (int i = 0; i < 2; i++) begin
            chk("t3_valid", 64'(valid), 64'd1);
            chk("t3_idx0",  64'(get_idx(0)), 64'd0);
            chk("t3_idx1",  64'(get_idx(1)), 64'(i));
            tick();
        end
        chk("t3_done", 64'(done), 64'd1);
        tick();

        // Test 4: ranges {2,2} with back-pressure; start in RUN ignored
        set_ranges(2, 2);
        ready = 1'b0;
        kick(3'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_valid", 64'(valid), 64'd1);
            chk("t4_idx0",  64'(get_idx(0)), 64'(q0[i]));
            chk("t4_idx1",  64'(get_idx(1)), 64'(q1[i]));
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("t4_hold_valid", 64'(valid), 64'd1);
            chk("t4_hold_idx0",  64'(get_idx(0)), 64'(q0[i]));
            chk("t4_hold_idx1",  64'(get_idx(1)), 64'(q1[i]));
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
        chk("t4_done", 64'(done), 64'd1);
        ready = 1'b1;
        tick();

        // Test 5: accum flag with boundary loop 0 then 1
        set_ranges(2, 3);
        kick(3'd0);
        for (int i = 0; i < 6; i++) begin
            chk("t5_accum_l0", 64'(accum), 64'(a0[i]));
            tick();
        end
        chk("t5_done_l0", 64'(done), 64'd1);
        tick();
        kick(3'd1);
        for (int i = 0; i < 6; i++) begin
            chk("t5_accum_l1", 64'(accum), 64'(a1[i]));
            tick();
        end
        chk("t5_done_l1", 64'(done), 64'd1);
        tick();

        // Test 6: clear at the 3rd iteration of test 1, then restart
        stride_v[0 +: RW] = 32'd4;
        set_ranges(3, 2);
        kick(3'd0);
        tick();
        tick();
        chk("t6_idx0_pre", 64'(get_idx(0)), 64'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_valid", 64'(valid), 64'd0);
        chk("t6_busy",  64'(busy), 64'd0);
        chk("t6_idx",   64'(idx == '0), 64'd1);
        chk("t6_offs",  64'(offs == '0), 64'd1);
        chk("t6_nodone", 64'(done), 64'd0);
        tick();
        chk("t6_nodone2", 64'(done), 64'd0);
        kick(3'd0);
        chk("t6_re_valid", 64'(valid), 64'd1);
        chk("t6_re_idx0",  64'(get_idx(0)), 64'd0);
        chk("t6_re_offs0", 64'(offs[0 +: RW]), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("t6_re_done", 64'(seen), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
